// File: rtl/riscv_mem_pkg.sv
// Shared types for the core memory port: load/store funct3 codes, sequencer states,
// access owners and the funct3/alignment legality check.
package riscv_mem_pkg;

    localparam logic [2:0] LS_B  = 3'd0;
    localparam logic [2:0] LS_H  = 3'd1;
    localparam logic [2:0] LS_W  = 3'd2;
    localparam logic [2:0] LS_BU = 3'd4;
    localparam logic [2:0] LS_HU = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        CAP   = 3'd2,
        WR    = 3'd3,
        ERR   = 3'd4,
        IFERR = 3'd5
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Illegal funct3 or misalignment; the range check depends on ADDR_W and lives in the top.
    function automatic logic ls_err(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic e;
        if (we) begin
            e = (f3 > LS_W);
        end else begin
            e = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        end
        if ((f3 == LS_H || f3 == LS_HU) && lo[0]) begin
            e = 1'b1;
        end
        if (f3 == LS_W && lo != 2'd0) begin
            e = 1'b1;
        end
        return e;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load byte/halfword extraction with sign/zero extension,
// and SB/SH merge of store data into the word read back from RAM.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[8*i_addr_lo +: 8];
    assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_load = i_word;
        case (i_funct3)
            LS_B:    o_load = {{24{w_byte[7]}}, w_byte};
            LS_BU:   o_load = {24'd0, w_byte};
            LS_H:    o_load = {{16{w_half[15]}}, w_half};
            LS_HU:   o_load = {16'd0, w_half};
            default: o_load = i_word;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE    = 2'(gi);
            localparam logic       LANE_HI = (gi >= 2);
            logic       w_sel;
            logic [7:0] w_src;

            // SH writes wdata byte 0 into the even lane and byte 1 into the odd lane of the half.
            assign w_sel = ((i_funct3 == LS_B) && (i_addr_lo == LANE)) ||
                           ((i_funct3 == LS_H) && (i_addr_lo[1] == LANE_HI));
            assign w_src = (i_funct3 == LS_H) ? i_wdata[8*(gi%2) +: 8] : i_wdata[7:0];
            assign o_merge[8*gi +: 8] = w_sel ? w_src : i_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_port_sequencer.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module mem_port_sequencer
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t              r_state;
    owner_t              r_owner;
    logic [ADDR_W+1:0]   r_addr;
    logic [2:0]          r_funct3;
    logic                r_we;
    logic [31:0]         r_wbuf;

    logic                w_if_err;
    logic                w_d_err;
    logic                w_grant_d;
    logic                w_grant_if;
    logic [31:0]         w_load;
    logic [31:0]         w_merge;

    assign w_if_err = if_addr[0] || ((if_addr >> (ADDR_W + 2)) != 32'd0);
    assign w_d_err  = ls_err(d_we, d_funct3, d_addr[1:0]) || ((d_addr >> (ADDR_W + 2)) != 32'd0);

`ifdef MEM_ARB_RR_EN
    owner_t r_last;

    // On a tie the requester not served last wins; resetting to fetch lets data win first.
    assign w_grant_d = d_req && (!if_req || (r_last == OWN_IF));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= OWN_IF;
        end else if (r_state == IDLE) begin
            if (w_grant_d) begin
                r_last <= OWN_D;
            end else if (if_req) begin
                r_last <= OWN_IF;
            end
        end
    end
`else
    assign w_grant_d = d_req;
`endif

    assign w_grant_if = if_req && !w_grant_d;

    mem_lane_align u_align (
        .i_word    (mem_rdata),
        .i_wdata   (r_wbuf),
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr[1:0]),
        .o_load    (w_load),
        .o_merge   (w_merge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_owner  <= OWN_IF;
            r_addr   <= '0;
            r_funct3 <= 3'd0;
            r_we     <= 1'b0;
            r_wbuf   <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_owner  <= OWN_D;
                        r_addr   <= d_addr[ADDR_W+1:0];
                        r_funct3 <= d_funct3;
                        r_we     <= d_we;
                        r_wbuf   <= d_wdata;
                        if (w_d_err) begin
                            r_state <= ERR;
                        end else if (d_we && d_funct3 == LS_W) begin
                            r_state <= WR;
                        end else begin
                            r_state <= RD;
                        end
                    end else if (w_grant_if) begin
                        r_owner  <= OWN_IF;
                        r_addr   <= if_addr[ADDR_W+1:0];
                        r_we     <= 1'b0;
                        r_state  <= w_if_err ? IFERR : RD;
                    end
                end
                RD: r_state <= CAP;
                CAP: begin
                    // Sub-word store: the read word comes back here and is merged for the write.
                    if (r_owner == OWN_D && r_we) begin
                        r_wbuf  <= w_merge;
                        r_state <= WR;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is high so an interrupted RMW write never reaches RAM.
    always_comb begin
        if_valid  = 1'b0;
        if_rdata  = 32'd0;
        if_err    = 1'b0;
        d_ack     = 1'b0;
        d_rdata   = 32'd0;
        d_err     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        if (!rst) begin
            case (r_state)
                RD: begin
                    mem_en   = 1'b1;
                    mem_addr = r_addr[ADDR_W+1:2];
                end
                CAP: begin
                    if (r_owner == OWN_IF) begin
                        if_valid = 1'b1;
                        if_rdata = mem_rdata;
                    end else if (!r_we) begin
                        d_ack   = 1'b1;
                        d_rdata = w_load;
                    end
                end
                WR: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = r_addr[ADDR_W+1:2];
                    mem_wdata = r_wbuf;
                    d_ack     = 1'b1;
                end
                ERR: begin
                    d_ack = 1'b1;
                    d_err = 1'b1;
                end
                IFERR: begin
                    if_valid = 1'b1;
                    if_err   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench for mem_port_sequencer: RAM model, transaction-level reference model and a
// per-cycle compare process against a queue of expected completions.
module tb_mem_port_sequencer;

    localparam int ADDR_W = 10;
    localparam int NWORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = 32'd0;
    logic              if_valid;
    logic [31:0]       if_rdata;
    logic              if_err;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [2:0]        d_funct3 = 3'd0;
    logic [31:0]       d_addr = 32'd0;
    logic [31:0]       d_wdata = 32'd0;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    mem_port_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:NWORDS-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
        bit          chk;
    } exp_t;

    exp_t        expq[$];
    exp_t        ce;
    logic [31:0] ref_mem [0:NWORDS-1];
    int          n_vec = 0;
    int          n_bad = 0;
    bit          no_mem = 1'b0;

    function automatic bit model_derr(input bit we, input logic [2:0] f3, input logic [31:0] a);
        if ((a >> (ADDR_W + 2)) != 32'd0) return 1'b1;
        if (we && f3 > 3'd2) return 1'b1;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2) != 0) return 1'b1;
        if (f3 == 3'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [2:0] f3,
                                                input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int          sh;
        if (f3 == 3'd0) begin
            sh   = 8 * int'(a % 4);
            mask = 32'hFF << sh;
            return (old & ~mask) | ((wd & 32'hFF) << sh);
        end else if (f3 == 3'd1) begin
            sh   = 16 * int'((a / 2) % 2);
            mask = 32'hFFFF << sh;
            return (old & ~mask) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].at < cyc) begin
            ce = expq.pop_front();
            n_vec++; n_bad++;
            $display("FAIL missed_ack: expected %s completion at cyc %0d", ce.is_d ? "data" : "fetch", ce.at);
        end
        if (rst) begin
            check("reset_outputs", {31'd0, if_valid | if_err | d_ack | d_err | mem_en | mem_we |
                  (|if_rdata) | (|d_rdata) | (|mem_addr) | (|mem_wdata)}, 32'd0);
        end else if (expq.size() > 0 && expq[0].at == cyc) begin
            ce = expq.pop_front();
            if (ce.is_d) begin
                check("d_ack", {31'd0, d_ack}, 32'd1);
                check("d_ack_no_ifvalid", {31'd0, if_valid}, 32'd0);
                check("d_err", {31'd0, d_err}, {31'd0, ce.err});
                if (ce.chk) check("d_rdata", d_rdata, ce.rdata);
            end else begin
                check("if_valid", {31'd0, if_valid}, 32'd1);
                check("if_valid_no_dack", {31'd0, d_ack}, 32'd0);
                check("if_err", {31'd0, if_err}, {31'd0, ce.err});
                if (ce.chk) check("if_rdata", if_rdata, ce.rdata);
            end
        end else begin
            check("idle_no_ack", {30'd0, d_ack, if_valid}, 32'd0);
        end
        if (no_mem) check("err_no_mem_en", {31'd0, mem_en}, 32'd0);
    end

    task automatic push_exp(input int at, input bit is_d, input logic [31:0] rd, input bit err, input bit chk);
        exp_t x;
        x.at = at; x.is_d = is_d; x.rdata = rd; x.err = err; x.chk = chk;
        expq.push_back(x);
    endtask

    // Called at a negedge while the DUT is idle; returns at a negedge with the DUT idle again.
    task automatic d_op(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input bit use_lit, input logic [31:0] lit);
        bit          err;
        bit          got;
        int          lat;
        int          widx;
        logic [31:0] exp_r;
        err   = model_derr(we, f3, a);
        widx  = int'(a[ADDR_W+1:2]);
        lat   = err ? 1 : (we && f3 == 3'd2) ? 1 : we ? 3 : 2;
        exp_r = (!we && !err) ? model_load(ref_mem[widx], f3, a) : 32'd0;
        push_exp(cyc + lat, 1'b1, exp_r, err, !we && !err);
        no_mem   = err;
        d_req    = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (d_ack) got = 1'b1;
        end
        check("d_ack_timeout", {31'd0, got}, 32'd1);
        if (use_lit) check("d_rdata_literal", d_rdata, lit);
        $display("data  we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d cyc=%0d",
                 we, f3, a, wd, d_rdata, d_err, cyc);
        d_req = 1'b0;
        if (we && !err) ref_mem[widx] = model_store(ref_mem[widx], f3, a, wd);
        @(negedge clk);
        no_mem = 1'b0;
    endtask

    task automatic f_op(input logic [31:0] a);
        bit err;
        bit got;
        err = (a % 2) != 0 || (a >> (ADDR_W + 2)) != 32'd0;
        push_exp(cyc + (err ? 1 : 2), 1'b0, err ? 32'd0 : ref_mem[int'(a[ADDR_W+1:2])], err, !err);
        no_mem  = err;
        if_req  = 1'b1; if_addr = a;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (if_valid) got = 1'b1;
        end
        check("if_valid_timeout", {31'd0, got}, 32'd1);
        $display("fetch addr=0x%08h -> rdata=0x%08h err=%0d cyc=%0d", a, if_rdata, if_err, cyc);
        if_req = 1'b0;
        @(negedge clk);
        no_mem = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        int          nd;
        int          ni;
        logic [3:0]  order;
        logic [31:0] w_before;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);

        d_op(1'b1, 3'd2, 32'h10,  32'h8899AABB, 1'b0, 32'd0);
        d_op(1'b1, 3'd2, 32'h100, 32'hCAFEF00D, 1'b0, 32'd0);
        d_op(1'b0, 3'd0, 32'h11,  32'd0, 1'b1, 32'hFFFFFFAA);
        d_op(1'b0, 3'd5, 32'h12,  32'd0, 1'b1, 32'h00008899);
        d_op(1'b0, 3'd1, 32'h12,  32'd0, 1'b1, 32'hFFFF8899);
        d_op(1'b0, 3'd2, 32'h10,  32'd0, 1'b1, 32'h8899AABB);
        d_op(1'b0, 3'd4, 32'h10,  32'd0, 1'b1, 32'h000000BB);
        d_op(1'b0, 3'd0, 32'h13,  32'd0, 1'b1, 32'hFFFFFF88);
        d_op(1'b0, 3'd1, 32'h10,  32'd0, 1'b1, 32'hFFFFAABB);
        d_op(1'b1, 3'd0, 32'h13,  32'h00000055, 1'b0, 32'd0);
        check("ram_after_sb", ram[4], 32'h5599AABB);
        d_op(1'b1, 3'd1, 32'h10,  32'h00001234, 1'b0, 32'd0);
        check("ram_after_sh", ram[4], 32'h55991234);
        d_op(1'b1, 3'd0, 32'h11,  32'hFFFFFF7E, 1'b0, 32'd0);
        d_op(1'b0, 3'd2, 32'h10,  32'd0, 1'b1, 32'h55997E34);
        d_op(1'b0, 3'd2, 32'h12,  32'd0, 1'b0, 32'd0);
        d_op(1'b0, 3'd1, 32'h11,  32'd0, 1'b0, 32'd0);
        d_op(1'b0, 3'd3, 32'h10,  32'd0, 1'b0, 32'd0);
        d_op(1'b0, 3'd6, 32'h10,  32'd0, 1'b0, 32'd0);
        d_op(1'b1, 3'd4, 32'h10,  32'h1, 1'b0, 32'd0);
        d_op(1'b1, 3'd1, 32'h11,  32'h1, 1'b0, 32'd0);
        d_op(1'b1, 3'd2, 32'h1000, 32'h1, 1'b0, 32'd0);
        d_op(1'b0, 3'd0, 32'h1000, 32'd0, 1'b0, 32'd0);
        f_op(32'h100);
        f_op(32'h102);
        f_op(32'h101);
        f_op(32'h1000);

        // Simultaneous requests, each side wanting two accesses.
        do_reset();
        c0 = cyc;
`ifdef MEM_ARB_RR_EN
        order = 4'b1010;
`else
        order = 4'b1100;
`endif
        for (int k = 0; k < 4; k++) begin
            push_exp(c0 + 2 + 3 * k, order[3-k], order[3-k] ? ref_mem[4] : ref_mem[64], 1'b0, 1'b1);
        end
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'd2; d_addr = 32'h10;
        if_req = 1'b1; if_addr = 32'h102;
        nd = 0; ni = 0;
        for (int i = 0; i < 40 && (nd < 2 || ni < 2); i++) begin
            @(negedge clk);
            if (d_ack) begin
                nd++;
                $display("arb   grant=D rdata=0x%08h cyc=%0d", d_rdata, cyc);
                if (nd == 2) d_req = 1'b0;
            end
            if (if_valid) begin
                ni++;
                $display("arb   grant=IF rdata=0x%08h cyc=%0d", if_rdata, cyc);
                check("arb_if_rdata_literal", if_rdata, 32'hCAFEF00D);
                if (ni == 2) if_req = 1'b0;
            end
        end
        check("arb_completions", nd * 4 + ni, 32'd10);
        d_req = 1'b0; if_req = 1'b0;
        @(negedge clk);

        // Reset during the write phase of an SB must leave RAM untouched.
        w_before = ram[4];
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'd0; d_addr = 32'h13; d_wdata = 32'h000000AA;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1; d_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", {31'd0, if_valid | if_err | d_ack | d_err | mem_en | mem_we |
              (|if_rdata) | (|d_rdata) | (|mem_addr) | (|mem_wdata)}, 32'd0);
        @(negedge clk);
        check("ram_after_aborted_sb", ram[4], w_before);
        $display("reset abort of SB 0x13 -> ram word 0x%08h cyc=%0d", ram[4], cyc);
        d_op(1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'h55997E34);

        repeat (3) @(negedge clk);
        check("expect_queue_drained", expq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
